// File: rtl/gb_mem_pkg.sv
// Shared constants and types for the Game Boy board memories (WRAM/VRAM).
// Both memories are byte-wide and power-on cleared by a sweep.
package gb_mem_pkg;

    localparam int         WRAM_DEPTH = 8192;
    localparam int         VRAM_DEPTH = 8192;
    localparam logic [7:0] OPEN_BUS   = 8'hFF;

    typedef enum logic {
        CLEAR,
        READY
    } mem_state_e;

endpackage

// File: rtl/gb_mem_clear_ctrl.sv
// Post-reset clear sequencer: walks every index writing zero, then reports init_done.
// The owning RAM muxes clr_we/clr_idx ahead of the external write port.
module gb_mem_clear_ctrl
    import gb_mem_pkg::*;
#(
    parameter int depth = WRAM_DEPTH
) (
    input  logic                     wr_clk,
    input  logic                     reset_n,
    output logic                     clr_we,
    output logic [$clog2(depth)-1:0] clr_idx,
    output logic                     init_done
);

    localparam int IW = $clog2(depth);

    mem_state_e       state_reg;
    logic [IW-1:0]    clr_ptr_reg;
    logic             init_done_reg;

    always_ff @(posedge wr_clk) begin
        if (!reset_n) begin
            state_reg     <= CLEAR;
            clr_ptr_reg   <= '0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + IW'(1);
                    if (clr_ptr_reg == IW'(depth - 1)) begin
                        state_reg     <= READY;
                        init_done_reg <= 1'b1;
                    end
                end
                READY: begin
                    state_reg <= READY;
                end
                default: begin
                    state_reg <= CLEAR;
                end
            endcase
        end
    end

    // The reset edge itself must not touch the array.
    assign clr_we    = reset_n && (state_reg == CLEAR);
    assign clr_idx   = clr_ptr_reg;
    assign init_done = init_done_reg;

endmodule

// File: rtl/gb_async_ram.sv
// Byte-wide RAM with combinational read and synchronous write, zero-cleared after reset.
// Reads outside rd_cs return the open-bus value (all ones).
module gb_async_ram
    import gb_mem_pkg::*;
#(
    parameter int asz   = 8,
    parameter int depth = WRAM_DEPTH
) (
    input  logic           wr_clk,
    input  logic           reset_n,
    input  logic [15:0]    addr,
    input  logic [asz-1:0] wr_data,
    input  logic           wr_cs,
    input  logic           rd_cs,
    output logic [asz-1:0] rd_data,
    output logic           init_done
);

    localparam int IW = $clog2(depth);

    logic [asz-1:0] mem [depth];
    logic [IW-1:0]  idx;
    logic [IW-1:0]  clr_idx;
    logic           clr_we;
    logic           ext_we;
    logic [asz-1:0] rd_word;

    gb_mem_clear_ctrl #(
        .depth(depth)
    ) u_clear_ctrl (
        .wr_clk   (wr_clk),
        .reset_n  (reset_n),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx),
        .init_done(init_done)
    );

    // Upper address bits alias onto the same storage.
    assign idx = addr[IW-1:0];

    generate
        if (IW < 16) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[15:IW];
        end
    endgenerate

    // External writes are dropped (not queued) until the sweep completes.
    assign ext_we = reset_n && init_done && wr_cs;

    always_ff @(posedge wr_clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (ext_we) begin
            mem[idx] <= wr_data;
        end
    end

    assign rd_word = mem[idx];

    genvar gi;
    generate
        for (gi = 0; gi < asz; gi++) begin : g_rd_bit
            assign rd_data[gi] = rd_cs ? rd_word[gi] : 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_gb_async_ram.sv
// Bench for gb_async_ram: a behavioural memory model checked every cycle,
// plus directed vectors with literal expected values.
module tb_gb_async_ram;

    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_cs = 1'b0;
    logic        rd_cs = 1'b0;
    logic [7:0]  rd_data;
    logic        init_done;

    int checks = 0;
    int passed = 0;

    // Model state: edges since last reset release, contents and "defined" map.
    int       since_rel = 0;
    bit       had_reset = 1'b0;
    logic [7:0] m_mem   [DEPTH];
    bit         m_known [DEPTH];

    gb_async_ram #(
        .asz  (8),
        .depth(DEPTH)
    ) dut (
        .wr_clk   (clk),
        .reset_n  (reset_n),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_cs    (wr_cs),
        .rd_cs    (rd_cs),
        .rd_data  (rd_data),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: location n is zeroed on the (n+1)-th edge after release; after
    // depth edges the RAM is ready and accepts wr_cs writes modulo depth.
    always @(posedge clk) begin
        if (!reset_n) begin
            had_reset <= 1'b1;
            since_rel <= 0;
        end else if (had_reset) begin
            if (since_rel < DEPTH) begin
                m_mem[since_rel]   <= 8'h00;
                m_known[since_rel] <= 1'b1;
                since_rel          <= since_rel + 1;
            end else if (wr_cs) begin
                m_mem[int'(addr) % DEPTH]   <= wr_data;
                m_known[int'(addr) % DEPTH] <= 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (had_reset) begin
            check("init_done_model", {31'd0, init_done}, {31'd0, (since_rel >= DEPTH)});
        end
        if (!rd_cs) begin
            check("open_bus_model", {24'd0, rd_data}, 32'h0000_00FF);
        end else if (m_known[int'(addr) % DEPTH]) begin
            check("rd_data_model", {24'd0, rd_data}, {24'd0, m_mem[int'(addr) % DEPTH]});
        end
    end

    // All drive tasks start and end at posedge+1.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
    endtask

    task automatic count_to_init(output int n);
        n = 0;
        while (!init_done && n < DEPTH + 100) begin
            tick(1);
            n++;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        addr    = a;
        wr_data = d;
        wr_cs   = 1'b1;
        tick(1);
        wr_cs   = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        addr  = a;
        rd_cs = 1'b1;
        #1;
        check(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    initial begin
        int n;
        tick(1);
        check("init_done_in_reset", {31'd0, init_done}, 32'd0);
        reset_n = 1'b1;

        count_to_init(n);
        check("sweep_length", n, DEPTH);
        read_check("clr_0000", 16'h0000, 8'h00);
        read_check("clr_1000", 16'h1000, 8'h00);
        read_check("clr_1FFF", 16'h1FFF, 8'h00);

        do_write(16'h0123, 8'hA5);
        read_check("wr_0123", 16'h0123, 8'hA5);
        rd_cs = 1'b0;
        #1;
        check("open_bus", {24'd0, rd_data}, 32'h0000_00FF);

        do_write(16'h2005, 8'h3C);
        read_check("alias_0005", 16'h0005, 8'h3C);
        read_check("alias_E005", 16'hE005, 8'h3C);
        do_write(16'hFFFF, 8'h6E);
        read_check("alias_1FFF", 16'h1FFF, 8'h6E);

        do_write(16'h0010, 8'h55);
        read_check("pre_reset_0010", 16'h0010, 8'h55);
        rd_cs = 1'b0;

        // Reset, attempt a write during the sweep, then restart the sweep mid-way.
        do_reset();
        tick(9);
        do_write(16'h1FFF, 8'h77);
        tick(4000 - 11);
        check("init_done_mid_sweep", {31'd0, init_done}, 32'd0);
        do_reset();
        check("init_done_after_rst2", {31'd0, init_done}, 32'd0);
        count_to_init(n);
        check("sweep_length_restart", n, DEPTH);
        read_check("clear_wr_ignored", 16'h1FFF, 8'h00);
        read_check("reset_clears_0010", 16'h0010, 8'h00);
        read_check("reset_clears_0123", 16'h0123, 8'h00);

        // Same-address read-during-write: new data visible right after the edge.
        do_write(16'h0042, 8'h11);
        addr    = 16'h0042;
        rd_cs   = 1'b1;
        wr_data = 8'h99;
        wr_cs   = 1'b1;
        #1;
        check("rw_before_edge", {24'd0, rd_data}, 32'h11);
        tick(1);
        wr_cs = 1'b0;
        check("rw_after_edge", {24'd0, rd_data}, 32'h99);
        tick(2);
        read_check("rw_hold", 16'h0042, 8'h99);

        rd_cs = 1'b0;
        tick(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
